// File: rtl/instr_encoder_loader.sv
// Program loader: encodes instruction descriptors into MIPS words and writes them sequentially into instruction memory.
// Optional build macro LOADER_NOP_PAD_EN fills the unused tail of memory with NOPs after END.
`timescale 1ns/1ps

module instr_encoder_loader #(
    parameter int MEMORY_DEPTH = 64,
    parameter int ADDR_WIDTH   = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_kind,
    input  logic [4:0]            in_rs,
    input  logic [4:0]            in_rt,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_shamt,
    input  logic [5:0]            in_funct,
    input  logic [15:0]           in_imm,
    input  logic [25:0]           in_target,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow_err,
    output logic [ADDR_WIDTH:0]   instr_count
);

    typedef enum logic [2:0] {
        KIND_R    = 3'd0,
        KIND_ADDI = 3'd1,
        KIND_ORI  = 3'd2,
        KIND_ANDI = 3'd3,
        KIND_BEQ  = 3'd4,
        KIND_BNE  = 3'd5,
        KIND_J    = 3'd6,
        KIND_END  = 3'd7
    } kindType;

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        WRITE,
`ifdef LOADER_NOP_PAD_EN
        PAD,
`endif
        DONE,
        ERROR
    } stateType;

    localparam logic [ADDR_WIDTH:0] DEPTH_PTR = (ADDR_WIDTH+1)'(MEMORY_DEPTH);

    stateType              state;
    kindType               kind;
    logic [ADDR_WIDTH:0]   ptr;
    logic [31:0]           encodedWord;
    logic                  memFull;

    assign kind    = kindType'(in_kind);
    assign memFull = (ptr == DEPTH_PTR);

    assign in_ready     = (state == ACCEPT);
    assign done         = (state == DONE);
    assign overflow_err = (state == ERROR);
`ifdef LOADER_NOP_PAD_EN
    assign busy = (state == ACCEPT) || (state == WRITE) || (state == PAD);
`else
    assign busy = (state == ACCEPT) || (state == WRITE);
`endif

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        encodedWord = 32'h0000_0000;
        case (kind)
            KIND_R:    encodedWord = {6'h00, in_rs, in_rt, in_rd, in_shamt, in_funct};
            KIND_ADDI: encodedWord = {6'h08, in_rs, in_rt, in_imm};
            KIND_ORI:  encodedWord = {6'h0d, in_rs, in_rt, in_imm};
            KIND_ANDI: encodedWord = {6'h0c, in_rs, in_rt, in_imm};
            KIND_BEQ:  encodedWord = {6'h04, in_rs, in_rt, in_imm};
            KIND_BNE:  encodedWord = {6'h05, in_rs, in_rt, in_imm};
            KIND_J:    encodedWord = {6'h02, in_target};
            default:   encodedWord = 32'h0000_0000;
        endcase
    end

    // NOTE: state uses non-blocking assignments; the async reset clears mem_we immediately, aborting any write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            ptr         <= '0;
            instr_count <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state       <= ACCEPT;
                        ptr         <= '0;
                        instr_count <= '0;
                    end
                end
                ACCEPT: begin
                    if (in_valid) begin
                        if (kind == KIND_END) begin
`ifdef LOADER_NOP_PAD_EN
                            if (memFull) begin
                                state <= DONE;
                            end else begin
                                state     <= PAD;
                                mem_we    <= 1'b1;
                                mem_addr  <= ptr[ADDR_WIDTH-1:0];
                                mem_wdata <= 32'h0000_0000;
                                ptr       <= ptr + 1'b1;
                            end
`else
                            state <= DONE;
`endif
                        end else if (memFull) begin
                            state <= ERROR;
                        end else begin
                            state     <= WRITE;
                            mem_we    <= 1'b1;
                            mem_addr  <= ptr[ADDR_WIDTH-1:0];
                            mem_wdata <= encodedWord;
                        end
                    end
                end
                WRITE: begin
                    state       <= ACCEPT;
                    ptr         <= ptr + 1'b1;
                    instr_count <= instr_count + 1'b1;
                end
`ifdef LOADER_NOP_PAD_EN
                PAD: begin
                    // Pointer already advanced past the word being written this cycle.
                    if (memFull) begin
                        state <= DONE;
                    end else begin
                        mem_we    <= 1'b1;
                        mem_addr  <= ptr[ADDR_WIDTH-1:0];
                        mem_wdata <= 32'h0000_0000;
                        ptr       <= ptr + 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the processor's opcode decoder: accepts instruction descriptions and encodes them into 32-bit MIPS words.
- Covers instruction class plus fields for R-type, ADDI, ORI, ANDI, BEQ, BNE and J.
- Writes encoded words sequentially into instruction memory through a write port.
- Used as a program loader ahead of the core: the core is held idle while `busy` is high.

Parameters:
- MEMORY_DEPTH, 64: number of instruction-memory words writable (must be ≥ 1).
- ADDR_WIDTH, 6: width of mem_addr; 2^ADDR_WIDTH ≥ MEMORY_DEPTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a load session at address 0.
- in_valid  input  1  instruction descriptor valid.
- in_ready  output  1  loader can accept a descriptor (combinational from state).
- in_kind  input  3  0=R-type, 1=ADDI, 2=ORI, 3=ANDI, 4=BEQ, 5=BNE, 6=J, 7=END.
- in_rs, in_rt, in_rd, in_shamt  input  5 each  register/shift fields.
- in_funct  input  6  R-type function code.
- in_imm  input  16  immediate / branch offset.
- in_target  input  26  jump target field.
- mem_we  output  1  instruction-memory write enable (registered).
- mem_addr  output  ADDR_WIDTH  word address of the write (registered).
- mem_wdata  output  32  encoded instruction (registered).
- busy  output  1  high in ACCEPT, WRITE and PAD.
- done  output  1  load finished normally; held.
- overflow_err  output  1  more instructions than MEMORY_DEPTH; held.
- instr_count  output  ADDR_WIDTH+1  instructions written this session.

Behaviour:
- Reset (async, reset=0): state IDLE; all outputs 0, including mem_we, mem_addr, mem_wdata, busy, done, overflow_err and instr_count. An internal write pointer (ADDR_WIDTH+1 bits) is cleared.
- Reset asserted mid-session aborts immediately. Any in-flight mem_we drops the same instant; nothing resumes after release.
- States: IDLE, ACCEPT, WRITE, PAD (optional), DONE, ERROR.
- IDLE:
  - start → ACCEPT; pointer=0, instr_count=0, done=0, overflow_err=0.
- ACCEPT:
  - in_ready=1. A handshake is in_valid & in_ready.
  - Handshake with kind=END → DONE (or PAD when the optional feature is compiled in).
  - Other kind with pointer==MEMORY_DEPTH → ERROR; no write occurs.
  - Otherwise the encoded word is registered → WRITE.
- Encoding (op = bits 31:26):
  - R: {6'h00, rs, rt, rd, shamt, funct}.
  - ADDI 6'h08, ORI 6'h0d, ANDI 6'h0c, BEQ 6'h04, BNE 6'h05: {op, rs, rt, imm}.
  - J: {6'h02, target}.
  - Unused fields for a kind are ignored.
- WRITE (exactly one cycle):
  - mem_we=1, mem_addr=pointer[ADDR_WIDTH-1:0], mem_wdata=encoded word.
  - On exit: pointer+1, instr_count+1, → ACCEPT.
  - in_ready=0, so a held in_valid is not consumed.
- Latency and throughput: handshake at cycle N gives mem_we high at N+1. Maximum throughput is one instruction per 2 cycles.
- DONE: done=1, busy=0, instr_count frozen. start → new session (same as from IDLE).
- ERROR: overflow_err=1, busy=0, done=0. start → new session.
- start is ignored in ACCEPT, WRITE and PAD.
- mem_we is 0 in every state except WRITE/PAD. mem_addr and mem_wdata hold their last values otherwise.
- Exactly MEMORY_DEPTH instructions followed by END is legal and ends in DONE.

Optional Feature:
- Macro: LOADER_NOP_PAD_EN.
- Defined: END goes to PAD. PAD writes 32'h00000000 (NOP) to each remaining address, pointer..MEMORY_DEPTH-1, one per cycle with mem_we=1. It then enters DONE.
  - instr_count counts only real instructions.
  - If pointer==MEMORY_DEPTH, PAD lasts 0 cycles.
- Undefined: END goes directly to DONE; the PAD state does not exist.

Test Plan:
- Reset mid-WRITE → mem_we falls without a clock edge; all outputs 0; in_ready=0 until the next start.
- start; ADDI rs=0 rt=8 imm=5; END → mem_we once, addr 0, data 32'h20080005; then done=1, instr_count=1.
- R-type rs=8 rt=9 rd=10 shamt=0 funct=6'h20, then J target=26'h0100004, then BNE rs=8 rt=9 imm=16'hFFFE → addr 0/1/2 receive 32'h01095020, 32'h08100004, 32'h1509FFFE.
- MEMORY_DEPTH=4, send 5 ORI then END → 4 writes (addr 0-3), overflow_err=1 on the 5th handshake, no 5th write, done=0, instr_count=4.
- in_valid held high continuously → in_ready alternates 1/0; each descriptor is consumed exactly once; a start pulse during WRITE is ignored.
- LOADER_NOP_PAD_EN with MEMORY_DEPTH=4: 1 ANDI then END → addr 0 = ANDI word; addr 1-3 = 0 on consecutive cycles; done=1, instr_count=1.
